// File: rtl/fb_pkg.sv
// Shared framebuffer constants, write-FSM state type and address-width helper.
package fb_pkg;

    localparam int FB_W_DEF = 160;
    localparam int FB_H_DEF = 120;
    localparam int COLOUR_W = 3;

    typedef enum logic {
        IDLE,
        CLEAR
    } fb_state_t;

    function automatic int fb_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Latency: read data valid one cycle after the address; write lands at the clock edge.
// Backpressure: none; a same-address read and write in one cycle returns the old word.
module fb_ram #(
    parameter int DEPTH  = 19200,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/plot_framebuffer.sv
// Plot receiver: queues in-range plots in a small FIFO and writes them to a 3-bpp framebuffer; includes clear engine.
// Latency: plot accepted at edge N is written at edge N+1 when idle; scan-out read has 1-cycle latency.
// Backpressure: none upstream; plots arriving while the FIFO is full are dropped and flagged in overflow.
module plot_framebuffer
    import fb_pkg::*;
#(
    parameter int         FB_W         = FB_W_DEF,
    parameter int         FB_H         = FB_H_DEF,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] xin,
    input  logic [10:0] yin,
    input  logic [2:0]  colourin,
    input  logic        plot,
    input  logic        clear,
    input  logic [11:0] rd_x,
    input  logic [10:0] rd_y,
    output logic [2:0]  rd_colour,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  oob_count
);

    localparam int NPIX   = FB_W * FB_H;
    localparam int ADDR_W = fb_addr_w(NPIX);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = ADDR_W + COLOUR_W;

    localparam logic [11:0]       X_LIM     = 12'(FB_W);
    localparam logic [10:0]       Y_LIM     = 11'(FB_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [11:0] x, input logic [10:0] y);
        return ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
    endfunction

    fb_state_t           state, state_nxt;
    logic [ADDR_W-1:0]   clr_addr;

    logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      fifo_cnt;
    logic                fifo_full, fifo_empty;
    logic                plot_in_range, flush, push, pop;
    logic [ADDR_W-1:0]   head_addr;
    logic [COLOUR_W-1:0] head_colour;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_wa, ram_ra;
    logic [COLOUR_W-1:0] ram_wd, ram_rd;
    logic                rd_in_range, rd_ok;

    assign plot_in_range = (xin < X_LIM) && (yin < Y_LIM);
    assign fifo_full     = (fifo_cnt == FULL_CNT);
    assign fifo_empty    = (fifo_cnt == '0);
    // Clear sampled in IDLE discards the queue, so the plot on that edge always has room.
    assign flush         = (state == IDLE) && clear;
    assign push          = plot && plot_in_range && (!fifo_full || flush);
    assign busy          = (state == CLEAR) || !fifo_empty;

    assign {head_addr, head_colour} = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ram_we    = 1'b0;
        ram_wa    = head_addr;
        ram_wd    = head_colour;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                end else if (!fifo_empty) begin
                    pop    = 1'b1;
                    ram_we = 1'b1;
                end
            end
            CLEAR: begin
                ram_we = 1'b1;
                ram_wa = clr_addr;
                ram_wd = CLEAR_COLOUR;
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            overflow  <= 1'b0;
            oob_count <= '0;
            rd_ok     <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_addr <= ((state == CLEAR) && (clr_addr != LAST_ADDR)) ? clr_addr + 1'b1 : '0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr   <= wr_ptr;
                fifo_cnt <= {{PTR_W{1'b0}}, push};
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_cnt <= fifo_cnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            end

            if (flush) begin
                overflow <= 1'b0;
            end else if (plot && plot_in_range && fifo_full) begin
                overflow <= 1'b1;
            end

            if (plot && !plot_in_range && (oob_count != 8'hFF)) begin
                oob_count <= oob_count + 8'd1;
            end

            rd_ok <= rd_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_mem[wr_ptr] <= {pix_addr(xin, yin), colourin};
        end
    end

    // Out-of-range reads are steered to address 0 and masked to zero on the output.
    assign rd_in_range = (rd_x < X_LIM) && (rd_y < Y_LIM);
    assign ram_ra      = rd_in_range ? pix_addr(rd_x, rd_y) : '0;
    assign rd_colour   = rd_ok ? ram_rd : 3'b000;

    fb_ram #(
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W),
        .DATA_W (COLOUR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_wa),
        .wr_dat  (ram_wd),
        .rd_addr (ram_ra),
        .rd_dat  (ram_rd)
    );

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: reset/clear timing, plot/read vectors, OOB saturation, overflow and flush.
module tb_plot_framebuffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] xin;
    logic [10:0] yin;
    logic [2:0]  colourin;
    logic        plot;
    logic        clear;
    logic [11:0] rd_x;
    logic [10:0] rd_y;
    logic [2:0]  rd_colour;
    logic        busy;
    logic        overflow;
    logic [7:0]  oob_count;

    int checks = 0;
    int errors = 0;

    plot_framebuffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .xin       (xin),
        .yin       (yin),
        .colourin  (colourin),
        .plot      (plot),
        .clear     (clear),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_colour (rd_colour),
        .busy      (busy),
        .overflow  (overflow),
        .oob_count (oob_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        plot;
        logic [11:0] x;
        logic [10:0] y;
        logic [2:0]  c;
        logic [11:0] rx;
        logic [10:0] ry;
        logic [2:0]  exp_rd;
        logic        exp_busy;
        logic [7:0]  exp_oob;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input int p, input int x, input int y, input int c,
                                input int rx, input int ry, input int erd, input int eb, input int eo);
        vec_t v;
        v.plot = 1'(p);  v.x = 12'(x);   v.y = 11'(y);   v.c = 3'(c);
        v.rx = 12'(rx);  v.ry = 11'(ry); v.exp_rd = 3'(erd);
        v.exp_busy = 1'(eb); v.exp_oob = 8'(eo);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_px(input int x, input int y, output logic [2:0] c);
        rd_x = 12'(x);
        rd_y = 11'(y);
        tick();
        c = rd_colour;
    endtask

    task automatic drive_plot(input int x, input int y, input int c);
        plot = 1'b1;
        xin = 12'(x);
        yin = 11'(y);
        colourin = 3'(c);
    endtask

    initial begin
        int n;
        int bad;
        logic [2:0] c;

        reset_n = 1'b0; plot = 1'b0; clear = 1'b0;
        xin = '0; yin = '0; colourin = '0; rd_x = '0; rd_y = '0;
        repeat (3) tick();
        check("reset rd_colour", rd_colour, 0);
        check("reset overflow", overflow, 0);
        check("reset oob_count", oob_count, 0);
        check("reset busy", busy, 1);

        // Queue plots during the power-up clear, then reset partway through it.
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) drive_plot(50 + i, 60, 7);
            else       drive_plot(200, 60, 7);
            tick();
        end
        plot = 1'b0;
        repeat (4990) tick();
        check("pre-reset overflow", overflow, 1);
        check("pre-reset oob_count", oob_count, 1);
        check("pre-reset busy", busy, 1);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid-reset rd_colour", rd_colour, 0);
        check("mid-reset overflow", overflow, 0);
        check("mid-reset oob_count", oob_count, 0);
        n = 0;
        while (busy && n < 30000) begin
            tick();
            n++;
        end
        check("reset clear busy cycles", n, 19200);

        bad = 0;
        for (int a = 0; a <= 19200; a++) begin
            if (a > 0 && rd_colour !== 3'b000) bad++;
            if (a < 19200) begin
                rd_x = 12'(a % 160);
                rd_y = 11'(a / 160);
            end
            tick();
        end
        check("scan all pixels zero", bad, 0);

        vecs[0]  = mk(1, 10, 5, 4,     10, 5,    0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0,      10, 5,    0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,      10, 5,    4, 0, 0);
        vecs[3]  = mk(1, 160, 0, 7,    0, 0,     0, 0, 1);
        vecs[4]  = mk(1, 0, 120, 7,    10, 5,    4, 0, 2);
        vecs[5]  = mk(1, 159, 119, 3,  160, 0,   0, 1, 2);
        vecs[6]  = mk(1, 0, 0, 5,      0, 120,   0, 1, 2);
        vecs[7]  = mk(0, 0, 0, 0,      159, 119, 3, 0, 2);
        vecs[8]  = mk(0, 0, 0, 0,      0, 0,     5, 0, 2);
        vecs[9]  = mk(0, 0, 0, 0,      0, 1,     0, 0, 2);
        vecs[10] = mk(1, 20, 20, 1,    0, 0,     5, 1, 2);
        vecs[11] = mk(1, 21, 20, 2,    10, 5,    4, 1, 2);
        vecs[12] = mk(1, 22, 20, 3,    20, 20,   1, 1, 2);
        vecs[13] = mk(1, 23, 20, 4,    21, 20,   2, 1, 2);
        vecs[14] = mk(0, 0, 0, 0,      22, 20,   3, 0, 2);
        vecs[15] = mk(0, 0, 0, 0,      23, 20,   4, 0, 2);
        vecs[16] = mk(0, 0, 0, 0,      24, 20,   0, 0, 2);
        vecs[17] = mk(0, 0, 0, 0,      159, 119, 3, 0, 2);

        for (int i = 0; i < 18; i++) begin
            plot = vecs[i].plot; xin = vecs[i].x; yin = vecs[i].y; colourin = vecs[i].c;
            rd_x = vecs[i].rx;   rd_y = vecs[i].ry;
            tick();
            check($sformatf("vec%0d rd_colour", i), rd_colour, vecs[i].exp_rd);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d oob_count", i), oob_count, vecs[i].exp_oob);
            check($sformatf("vec%0d overflow", i), overflow, 0);
        end
        plot = 1'b0;

        for (int i = 0; i < 300; i++) begin
            drive_plot(300 + i, i % 3, 1);
            tick();
        end
        plot = 1'b0;
        check("oob saturation", oob_count, 255);

        // Clear, then nine plots while clearing: eight queue, ninth overflows.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            drive_plot(30 + i, 40, (i % 7) + 1);
            tick();
            n++;
        end
        plot = 1'b0;
        check("overflow after 9th plot", overflow, 1);
        while (busy && n < 40000) begin
            tick();
            n++;
        end
        check("clear+8 pops busy cycles", n, 19208);
        check("overflow sticky after clear", overflow, 1);
        read_px(10, 5, c);
        check("cleared (10,5)", c, 0);
        for (int i = 0; i < 9; i++) begin
            read_px(30 + i, 40, c);
            check($sformatf("queued pixel %0d", i), c, (i < 8) ? (i % 7) + 1 : 0);
        end

        // Three plots, then clear together with a fourth.
        drive_plot(2, 2, 7); tick();
        drive_plot(3, 3, 6); tick();
        drive_plot(4, 4, 5); tick();
        drive_plot(1, 1, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        plot = 1'b0;
        check("overflow cleared on clear entry", overflow, 0);
        n = 0;
        while (busy && n < 40000) begin
            tick();
            n++;
        end
        check("flush clear busy cycles", n, 19201);
        read_px(1, 1, c); check("flush kept (1,1)", c, 2);
        read_px(2, 2, c); check("flushed (2,2)", c, 0);
        read_px(3, 3, c); check("flushed (3,3)", c, 0);
        read_px(4, 4, c); check("flushed (4,4)", c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plot_framebuffer.md
# plot_framebuffer

Receiving end of the pixel-plot interface driven by the graphics and drawing blocks. It accepts fire-and-forget plot strobes carrying x, y and colour, buffers them in a small FIFO, and writes them into an on-chip 3-bit-per-pixel framebuffer. It also provides a hardware clear engine and a synchronous read port for the scan-out logic.

## Interface
Parameters:
- FB_W, default 160: framebuffer width in pixels.
- FB_H, default 120: framebuffer height in pixels.
- FIFO_DEPTH, default 8: plot FIFO entries; must be a power of 2.
- CLEAR_COLOUR, default 3'b000: colour written by the clear engine.

Ports:
- clk, input, 1: system clock; single clock domain.
- reset_n, input, 1: synchronous, active-low reset.
- xin, input, 12: plot x coordinate.
- yin, input, 11: plot y coordinate.
- colourin, input, 3: plot colour.
- plot, input, 1: plot strobe; one pixel per cycle while high.
- clear, input, 1: start a full-screen clear.
- rd_x, input, 12: scan-out read x.
- rd_y, input, 11: scan-out read y.
- rd_colour, output, 3: pixel at (rd_x, rd_y); 1-cycle latency.
- busy, output, 1: high while clear is active or the FIFO is non-empty.
- overflow, output, 1: sticky; a plot was dropped because the FIFO was full.
- oob_count, output, 8: saturating count of plots rejected for out-of-range coordinates.

## Operation
- Plot acceptance:
  - At each edge with plot=1, a plot with xin<FB_W and yin<FB_H is pushed as {addr, colour}, where addr = yin*FB_W + xin (15 bits for the defaults; constant multiply).
  - A plot with xin>=FB_W or yin>=FB_H is discarded and oob_count increments; it saturates at 255.
  - A plot arriving while the FIFO count equals FIFO_DEPTH at the start of the cycle is dropped and sets overflow. A pop in the same cycle does not rescue it.
- Write FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and write it to RAM in the same cycle.
  - CLEAR: write CLEAR_COLOUR to address clr_addr and increment clr_addr each cycle. After address FB_W*FB_H-1, go to IDLE.
- Transitions:
  - IDLE to CLEAR on clear=1.
  - clear=1 while already in CLEAR is ignored; the clear does not restart.
- Clear flushes the FIFO:
  - All entries present at the edge where clear is sampled in IDLE are discarded.
  - A plot presented on that same edge is kept and is written after the clear completes.
  - Plots arriving during CLEAR queue normally, subject to overflow.
  - Entering CLEAR resets overflow to 0.
- Reset:
  - On reset, outputs go to rd_colour=0, overflow=0, oob_count=0. The FIFO is emptied.
  - The FSM enters CLEAR with clr_addr=0, so busy=1 on the first cycle after reset_n rises.
  - Reset asserted mid-clear restarts the clear from address 0.
  - RAM is never reset directly.
- Read port: rd_colour is the RAM word at rd_y*FB_W + rd_x, registered. Out-of-range read coordinates return 3'b000.
- Write and read on the same address in the same cycle: the read returns the old data.

## Timing
- A plot accepted at edge N with the FIFO empty and FSM in IDLE is written to RAM at edge N+1.
- A read addressed at edge N+1 sees the old data; a read addressed at N+2 returns the new colour after edge N+2.
- Sustained throughput is one plot per cycle with no FIFO growth.
- Clear duration is exactly FB_W*FB_H cycles: 19200 for the defaults.
- busy falls on the edge after the last clear write, provided the FIFO is empty.
- With queued entries, busy falls on the edge after the last pop.
- overflow is sticky until reset or entry into CLEAR.

## Structure
- Shared package `fb_pkg`:
  - FB_W and FB_H defaults.
  - Address width function (clog2 of FB_W*FB_H).
  - Colour width 3.
  - FSM state enum {IDLE, CLEAR}.
- Sub-module `fb_ram`:
  - Simple dual-port synchronous RAM: one write port, one read port.
  - Registered read output.
  - Depth FB_W*FB_H, 3-bit words.
  - Inferable as block RAM.
- The FIFO, address calculation, FSM and counters stay in plot_framebuffer.

## Test plan
- Reset release: busy=1 for exactly 19200 cycles; every location then reads 3'b000.
- After the clear, plot (x=10, y=5, colour=3'b100) at edge N: a read of (10,5) addressed at N+2 returns 3'b100, and addressed at N+1 returns 3'b000.
- Plot (x=160, y=0) and (x=0, y=120): RAM is unchanged and oob_count=2. Then 300 out-of-range plots: oob_count saturates at 255.
- Assert clear, then plot 9 distinct pixels on consecutive cycles during CLEAR:
  - The first 8 are written after the clear and the 9th is dropped.
  - overflow=1 and busy falls 8 cycles after the clear ends.
- Push 3 plots, then assert clear together with a 4th plot (x=1, y=1, colour=3'b010):
  - The first 3 are flushed.
  - After the clear, (1,1) reads 3'b010 and the other three locations read 3'b000.
- Assert reset_n=0 for one cycle at clear address 5000: the clear restarts at 0 and busy stays high for a further 19200 cycles.
